muldiv_sequencer: RTL

- Multi-cycle execution controller for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), attached to the EX stage beside the main ALU.
- Accepts an M-extension op, holds the pipeline with a stall signal, and sequences a 2-cycle multiply path or a 32-iteration restoring divider.
- Resolves RISC-V divide special cases early and returns a single-cycle done pulse with the result.

---
 rtl/muldiv_sequencer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle RV32M execution controller beside the EX-stage ALU.
//            It runs a 2-cycle multiply path or a XLEN-iteration restoring
//            divider. Divide-by-zero and signed overflow resolve in one cycle.
//            The pipeline is held with stall while an op runs, and the
//            result comes with a one-cycle done pulse.
// Ports    : clk    - system clock, rising edge
//            rst    - synchronous active-high reset
//            start  - EX stage holds a valid M-extension instruction
//            funct3 - op select (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//            rs1    - operand A / dividend
//            rs2    - operand B / divisor
//            flush  - pipeline redirect; aborts the op in flight
//            stall  - freeze PC, IF/ID, ID/EX while an op is in progress
//            done   - one-cycle pulse, result valid
//            result - registered result of the last completed op
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            c_CW   = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [1:0]      r_fn;          // funct3[1:0] of the accepted op
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;         // holds the dividend, shifted out as quotient bits enter
    logic [XLEN-1:0] r_divisor;     // divisor magnitude
    logic            r_quo_neg;
    logic            r_rem_neg;
    logic [c_CW-1:0] r_counter;
    logic [XLEN-1:0] r_result;

    // ------------------------------------------------------------------
    // Decode on the incoming operands (used only in IDLE)
    // ------------------------------------------------------------------
    logic            w_signed_div;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;

    assign w_signed_div  = ~funct3[0];
    assign w_div_zero    = (rs2 == '0);
    assign w_div_ovf     = w_signed_div & (rs1 == c_MIN) & (rs2 == '1);
    assign w_special     = w_div_zero | w_div_ovf;
    // funct3[1] selects REM/REMU over DIV/DIVU
    assign w_special_res = funct3[1] ? (w_div_zero ? rs1 : '0)
                                     : (w_div_zero ? '1  : c_MIN);
    assign w_abs_a       = (w_signed_div & rs1[XLEN-1]) ? -rs1 : rs1;
    assign w_abs_b       = (w_signed_div & rs2[XLEN-1]) ? -rs2 : rs2;

    // ------------------------------------------------------------------
    // Multiply path: operands sign-extended to 2*XLEN as the op requires
    // ------------------------------------------------------------------
    logic            w_a_signed;
    logic            w_b_signed;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_product;
    logic [XLEN-1:0] w_mul_res;

    assign w_a_signed = (r_fn != 2'b11);   // only MULHU treats rs1 as unsigned
    assign w_b_signed = ~r_fn[1];          // MULHSU and MULHU treat rs2 as unsigned
    assign w_a_ext    = {{XLEN{w_a_signed & r_op_a[XLEN-1]}}, r_op_a};
    assign w_b_ext    = {{XLEN{w_b_signed & r_op_b[XLEN-1]}}, r_op_b};
    assign w_product  = w_a_ext * w_b_ext;
    assign w_mul_res  = (r_fn == 2'b00) ? w_product[XLEN-1:0]
                                        : w_product[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------
    // Restoring divide step. The shifted partial remainder needs XLEN+1
    // bits because unsigned divisors can use the full XLEN range. When the
    // trial succeeds the difference is below the divisor, so its low XLEN
    // bits are exact.
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_div_res;

    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_diff     = w_shift[XLEN-1:0] - r_divisor;
    assign w_rem_next = w_ge ? w_diff : w_shift[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_ge};
    assign w_div_res  = r_fn[1] ? (r_rem_neg ? -w_rem_next : w_rem_next)
                                : (r_quo_neg ? -w_quo_next : w_quo_next);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = start & ~flush;
                if (start) begin
                    if (!funct3[2]) begin
                        w_next = S_MUL;
                    end else if (w_special) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL: begin
                stall  = 1'b1;
                w_next = S_DONE;
            end
            S_DIV: begin
                stall = 1'b1;
                if (r_counter == c_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fn      <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_quo_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_counter <= '0;
            r_result  <= '0;
        end else if (flush) begin
            // Abort: the result of the last completed op is kept
            r_counter <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_fn      <= funct3[1:0];
                        r_op_a    <= rs1;
                        r_op_b    <= rs2;
                        r_counter <= '0;
                        if (funct3[2]) begin
                            if (w_special) begin
                                r_result <= w_special_res;
                            end else begin
                                r_rem     <= '0;
                                r_quo     <= w_abs_a;
                                r_divisor <= w_abs_b;
                                r_quo_neg <= w_signed_div & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                                r_rem_neg <= w_signed_div & rs1[XLEN-1];
                            end
                        end
                    end
                end
                S_MUL: begin
                    r_result <= w_mul_res;
                end
                S_DIV: begin
                    r_rem     <= w_rem_next;
                    r_quo     <= w_quo_next;
                    r_counter <= r_counter + c_CW'(1);
                    if (r_counter == c_LAST) begin
                        r_result <= w_div_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire
